// File: rtl/dmem_copy_if.sv
// dmem_copy_if: command, status and RAM-port bundle between a controller and the copy engine
interface dmem_copy_if #(
  parameter int DWIDTH     = 16,
  parameter int ADDR_WIDTH = 16
);
  logic                  start;
  logic                  mode;
  logic [ADDR_WIDTH-1:0] src_addr;
  logic [ADDR_WIDTH-1:0] dst_addr;
  logic [ADDR_WIDTH-1:0] len;
  logic [DWIDTH-1:0]     fill_data;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0]     mem_data;
  logic                  mem_we;
  logic [DWIDTH-1:0]     mem_dout;
  modport master (
    output start, mode, src_addr, dst_addr, len, fill_data, mem_dout,
    input  busy, done, mem_addr, mem_data, mem_we
  );
  modport slave (
    input  start, mode, src_addr, dst_addr, len, fill_data, mem_dout,
    output busy, done, mem_addr, mem_data, mem_we
  );
endinterface

// File: rtl/dmem_copy_engine.sv
// dmem_copy_engine: block copy / fill master driving the single-port data RAM
module dmem_copy_engine #(
  parameter int DWIDTH     = 16,
  parameter int ADDR_WIDTH = 16
) (
  input logic         clk,
  input logic         rst_n,
  dmem_copy_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  localparam logic [ADDR_WIDTH-1:0] addr_one = 1;
  state_t                state, state_nx;
  logic                  fill_mode, desc;
  logic [ADDR_WIDTH-1:0] src_ptr, dst_ptr, cnt, last_ofs;
  logic [DWIDTH-1:0]     data_buf, fill_val;
  logic [ADDR_WIDTH:0]   src_end;
  logic                  overlap, accept;
  // Overlap test in one extra bit so src+len never wraps below dst
  assign src_end  = {1'b0, bus.src_addr} + {1'b0, bus.len};
  assign overlap  = !bus.mode && ({1'b0, bus.dst_addr} > {1'b0, bus.src_addr}) && ({1'b0, bus.dst_addr} < src_end);
  assign last_ofs = bus.len - addr_one;
  assign accept   = (state == IDLE) && bus.start;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = !bus.start ? IDLE : (bus.len == '0) ? DONE : bus.mode ? WRITE : READ;
      READ:    state_nx = WRITE;
      WRITE:   state_nx = (cnt == addr_one) ? DONE : fill_mode ? WRITE : READ;
      default: state_nx = IDLE;
    endcase
  end
  // Outputs decode from registered state only, keeping mem_we glitch-free
  assign bus.busy     = (state == READ) || (state == WRITE);
  assign bus.done     = state == DONE;
  assign bus.mem_we   = state == WRITE;
  assign bus.mem_addr = (state == READ) ? src_ptr : (state == WRITE) ? dst_ptr : '0;
  assign bus.mem_data = (state != WRITE) ? '0 : fill_mode ? fill_val : data_buf;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      fill_mode <= 1'b0;
      desc      <= 1'b0;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      cnt       <= '0;
      data_buf  <= '0;
      fill_val  <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        fill_mode <= bus.mode;
        desc      <= overlap;
        src_ptr   <= overlap ? bus.src_addr + last_ofs : bus.src_addr;
        dst_ptr   <= overlap ? bus.dst_addr + last_ofs : bus.dst_addr;
        cnt       <= bus.len;
        fill_val  <= bus.fill_data;
      end
      if (state == READ) begin
        data_buf <= bus.mem_dout;
        src_ptr  <= desc ? src_ptr - addr_one : src_ptr + addr_one;
      end
      if (state == WRITE) begin
        dst_ptr <= desc ? dst_ptr - addr_one : dst_ptr + addr_one;
        cnt     <= cnt - addr_one;
      end
    end
  end
endmodule

// File: tb/tb_dmem_copy_engine.sv
// tb_dmem_copy_engine: directed table of copy/fill commands against a behavioural RAM, plus reset corner cases
module tb_dmem_copy_engine;
  typedef struct {
    logic        mode;
    logic [15:0] src, dst, len, fill;
    int          done_cyc, busy_cnt, we_cnt, first_we_cyc;
    logic [15:0] first_we_addr, last_we_addr, first_rd_addr;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n;
  logic tb_we;
  logic [15:0] tb_addr, tb_data;
  logic [15:0] mem [65536];
  int n_chk = 0;
  int n_fail = 0;
  vec_t vecs [7];
  always #5 clk = ~clk;
  dmem_copy_if #(.DWIDTH(16), .ADDR_WIDTH(16)) bus ();
  dmem_copy_engine #(.DWIDTH(16), .ADDR_WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  assign bus.mem_dout = bus.mem_we ? 16'h0 : mem[bus.mem_addr];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_data;
    else if (tb_we) mem[tb_addr] <= tb_data;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    tb_we = 1'b1; tb_addr = a; tb_data = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask
  task automatic run(input int id, input vec_t v);
    logic [15:0] exp_d [8];
    logic [15:0] g_lo, g_hi, a, fw, lw, fr;
    int done_cyc, busy_cnt, we_cnt, first_we, bad_par;
    logic got_rd, busy_at_done, idle_after;
    done_cyc = 0; busy_cnt = 0; we_cnt = 0; first_we = 0; bad_par = 0;
    fw = '0; lw = '0; fr = '0; got_rd = 1'b0; busy_at_done = 1'b0;
    g_lo = mem[v.dst - 16'd1];
    g_hi = mem[v.dst + v.len];
    for (int i = 0; i < int'(v.len); i++) begin
      a = v.src + 16'(i);
      exp_d[i] = v.mode ? v.fill : mem[a];
    end
    bus.start = 1'b1; bus.mode = v.mode; bus.src_addr = v.src;
    bus.dst_addr = v.dst; bus.len = v.len; bus.fill_data = v.fill;
    @(posedge clk);
    for (int c = 1; c <= 100 && done_cyc == 0; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.busy) busy_cnt++;
      if (bus.mem_we) begin
        we_cnt++;
        if (first_we == 0) begin first_we = c; fw = bus.mem_addr; end
        lw = bus.mem_addr;
        if (!v.mode && (c % 2 == 1)) bad_par++;
      end else if (bus.busy && !got_rd) begin
        got_rd = 1'b1; fr = bus.mem_addr;
      end
      if (bus.done) begin done_cyc = c; busy_at_done = bus.busy; end
    end
    @(negedge clk);
    idle_after = bus.busy || bus.done || bus.mem_we || (bus.mem_addr != 16'h0);
    chk($sformatf("v%0d done_cycle", id), done_cyc, v.done_cyc);
    chk($sformatf("v%0d busy_cycles", id), busy_cnt, v.busy_cnt);
    chk($sformatf("v%0d we_cycles", id), we_cnt, v.we_cnt);
    chk($sformatf("v%0d busy_at_done", id), busy_at_done, 0);
    chk($sformatf("v%0d idle_after_done", id), idle_after, 0);
    chk($sformatf("v%0d we_parity", id), bad_par, 0);
    if (v.we_cnt > 0) begin
      chk($sformatf("v%0d first_we_cycle", id), first_we, v.first_we_cyc);
      chk($sformatf("v%0d first_we_addr", id), fw, v.first_we_addr);
      chk($sformatf("v%0d last_we_addr", id), lw, v.last_we_addr);
      if (!v.mode) chk($sformatf("v%0d first_rd_addr", id), fr, v.first_rd_addr);
    end
    chk($sformatf("v%0d guard_below", id), mem[v.dst - 16'd1], g_lo);
    chk($sformatf("v%0d guard_above", id), mem[v.dst + v.len], g_hi);
    for (int i = 0; i < int'(v.len); i++) begin
      a = v.dst + 16'(i);
      chk($sformatf("v%0d data[%0h]", id, a), mem[a], exp_d[i]);
    end
  endtask
  initial begin
    logic [15:0] o10, o41, o50;
    logic any_done;
    vec_t fup;
    vecs[0] = '{1'b0, 16'h0010, 16'h0020, 16'd3, 16'h0000, 7, 6, 3, 2, 16'h0020, 16'h0022, 16'h0010};
    vecs[1] = '{1'b1, 16'h0000, 16'h0100, 16'd4, 16'hBEEF, 5, 4, 4, 1, 16'h0100, 16'h0103, 16'h0000};
    vecs[2] = '{1'b0, 16'h0010, 16'h0012, 16'd4, 16'h0000, 9, 8, 4, 2, 16'h0015, 16'h0012, 16'h0013};
    vecs[3] = '{1'b0, 16'h0010, 16'h0030, 16'd0, 16'h0000, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000};
    vecs[4] = '{1'b1, 16'h0000, 16'hFFFE, 16'd3, 16'h1234, 4, 3, 3, 1, 16'hFFFE, 16'h0000, 16'h0000};
    vecs[5] = '{1'b0, 16'h0030, 16'h002E, 16'd4, 16'h0000, 9, 8, 4, 2, 16'h002E, 16'h0031, 16'h0030};
    vecs[6] = '{1'b0, 16'hFFFE, 16'hFFFF, 16'd2, 16'h0000, 5, 4, 2, 2, 16'h0000, 16'hFFFF, 16'hFFFF};
    fup     = '{1'b1, 16'h0000, 16'h0060, 16'd1, 16'h5A5A, 2, 1, 1, 1, 16'h0060, 16'h0060, 16'h0000};
    rst_n = 1'b0; tb_we = 1'b0; tb_addr = '0; tb_data = '0;
    bus.start = 1'b0; bus.mode = 1'b0; bus.src_addr = '0; bus.dst_addr = '0; bus.len = '0; bus.fill_data = '0;
    #2;
    chk("reset busy", bus.busy, 0);
    chk("reset done", bus.done, 0);
    chk("reset mem_we", bus.mem_we, 0);
    chk("reset mem_addr", bus.mem_addr, 0);
    chk("reset mem_data", bus.mem_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i == 0) begin preload(16'h0010, 16'h00A1); preload(16'h0011, 16'h00B2); preload(16'h0012, 16'h00C3); end
      if (i == 2) for (int k = 0; k < 4; k++) preload(16'h0010 + 16'(k), 16'(k + 1));
      if (i == 4) begin preload(16'hFFFD, 16'h0F0F); preload(16'h0001, 16'h7777); end
      if (i == 5) for (int k = 0; k < 4; k++) preload(16'h0030 + 16'(k), 16'h1111 * 16'(k + 1));
      if (i == 6) begin preload(16'hFFFE, 16'hAAAA); preload(16'hFFFF, 16'hBBBB); preload(16'h0001, 16'h0C0C); end
      run(i, vecs[i]);
      if (i == 0) begin
        chk("asc copy 0x20", mem[16'h0020], 16'h00A1);
        chk("asc copy 0x22", mem[16'h0022], 16'h00C3);
      end
      if (i == 2) for (int k = 0; k < 4; k++) chk($sformatf("overlap 0x%0h", 16'h12 + k), mem[16'h0012 + 16'(k)], k + 1);
      if (i == 6) begin
        chk("wrap copy 0xFFFF", mem[16'hFFFF], 16'hAAAA);
        chk("wrap copy 0x0000", mem[16'h0000], 16'hBBBB);
      end
    end
    o10 = mem[16'h0010]; o41 = mem[16'h0041]; o50 = mem[16'h0050];
    bus.start = 1'b1; bus.mode = 1'b0; bus.src_addr = 16'h0010; bus.dst_addr = 16'h0040; bus.len = 16'd4; bus.fill_data = '0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("midrst we cycle2", bus.mem_we, 1);
    chk("midrst addr cycle2", bus.mem_addr, 16'h0040);
    bus.start = 1'b1; bus.mode = 1'b1; bus.dst_addr = 16'h0050; bus.len = 16'd1; bus.fill_data = 16'hDEAD;
    @(posedge clk);
    #1;
    chk("ignored start busy", bus.busy, 1);
    chk("ignored start we", bus.mem_we, 0);
    chk("ignored start addr", bus.mem_addr, 16'h0011);
    bus.start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async rst busy", bus.busy, 0);
    chk("async rst we", bus.mem_we, 0);
    chk("async rst addr", bus.mem_addr, 0);
    any_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done) any_done = 1'b1;
    end
    chk("no done after reset", any_done, 0);
    rst_n = 1'b1;
    chk("partial write kept", mem[16'h0040], o10);
    chk("unwritten untouched", mem[16'h0041], o41);
    chk("ignored fill untouched", mem[16'h0050], o50);
    run(7, fup);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dmem_copy_engine.md
# dmem_copy_engine

Block-transfer master for the data memory: on a start command it either copies `len` words from `src_addr` to `dst_addr` or fills `len` words at `dst_addr` with a constant. It drives the single-port data RAM interface directly. That interface has a combinational read when write-enable is low, a synchronous write on the clock edge, and forces read data to 0 while write-enable is high. The engine sits beside the core and owns the RAM port while `busy` is high.

## Interface
- `DWIDTH`, 16, data word width
- `ADDR_WIDTH`, 16, word address width; all address arithmetic is modulo 2^ADDR_WIDTH

- `clk`  in  1  clock; all state changes occur on its rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  command strobe; sampled only in IDLE
- `mode`  in  1  0 = copy, 1 = fill; captured with `start`
- `src_addr`  in  ADDR_WIDTH  copy source base address; captured with `start`
- `dst_addr`  in  ADDR_WIDTH  destination base address; captured with `start`
- `len`  in  ADDR_WIDTH  word count (0 is legal); captured with `start`
- `fill_data`  in  DWIDTH  fill value; captured with `start`
- `busy`  out  1  high in READ and WRITE states
- `done`  out  1  single-cycle pulse in DONE state
- `mem_addr`  out  ADDR_WIDTH  RAM address
- `mem_data`  out  DWIDTH  RAM write data
- `mem_we`  out  1  RAM write enable
- `mem_dout`  in  DWIDTH  RAM read data (combinational from `mem_addr`)

## Operation
- States: IDLE, READ, WRITE, DONE. All outputs decode from registered state and registers only, so `mem_we` is glitch-free.
- **IDLE:**
  - Outputs: `mem_we`=0, `mem_addr`=0, `mem_data`=0.
  - On `start`=1, all command inputs are captured.
  - Next state: DONE if `len`==0; otherwise READ (copy) or WRITE (fill).
  - `start` is ignored in every other state.
- **Direction:** a copy runs descending when `dst_addr` > `src_addr` and `dst_addr` < `src_addr`+`len`. This comparison is computed in ADDR_WIDTH+1 bits, with no wrap.
  - Descending: pointers start at base+`len`−1 and decrement.
  - All other copies, and every fill, run ascending from base and increment.
  - Result: an overlapping copy always yields the original source contents at the destination.
- **READ:** `mem_addr`=src_ptr, `mem_we`=0. On the clock edge, `buf`<=`mem_dout`, src_ptr steps, then go to WRITE.
- **WRITE:**
  - Drives `mem_addr`=dst_ptr, `mem_we`=1.
  - Drives `mem_data`=`buf` for a copy, or the captured fill value for a fill.
  - On the clock edge, dst_ptr steps and remaining count decrements.
  - Next state: DONE if the count was 1; otherwise READ (copy) or WRITE (fill).
- **DONE:** `done`=1, `busy`=0, `mem_we`=0, then unconditionally IDLE.
- **Pointer wrap:** pointers wrap modulo 2^ADDR_WIDTH; 0xFFFF+1 = 0x0000 and 0x0000−1 = 0xFFFF.
- **Reset:** asynchronous assertion forces IDLE immediately.
  - `busy`=0, `done`=0, `mem_we`=0, `mem_addr`=0, `mem_data`=0, `buf`=0, pointers and count = 0.
  - A transfer interrupted by reset is abandoned: words already written stay written, and no `done` is produced.

## Timing
- Cycle 0 is the cycle in which `start`=1 is sampled in IDLE.
- **Copy of N words:**
  - READ in odd cycles 1,3,…,2N−1; WRITE in even cycles 2,…,2N; DONE in cycle 2N+1.
  - `busy` is high for 2N cycles.
- **Fill of N words:** WRITE in cycles 1..N, DONE in cycle N+1, `busy` high for N cycles.
- **len=0:** DONE in cycle 1; `mem_we` never asserts.
- Earliest next accepted `start` is the cycle after DONE.
- A RAM write takes effect at the rising edge that ends its WRITE cycle. A READ of that same address in the following cycle returns the new data.
- Throughput: one word per 2 cycles for copy, one word per cycle for fill.

## Test plan
- **Ascending copy:** preload 0x0010..0x0012 = 0x00A1, 0x00B2, 0x00C3. Start copy src=0x0010, dst=0x0020, len=3.
  - Required: 0x0020..0x0022 hold the same values; `mem_we` high in cycles 2, 4, 6; `done` in cycle 7 only; `busy` high cycles 1–6.
- **Fill:** fill dst=0x0100, len=4, `fill_data`=0xBEEF.
  - Required: 0x0100..0x0103 = 0xBEEF; `mem_we` high cycles 1–4; `done` in cycle 5; 0x00FF and 0x0104 unchanged.
- **Overlapping forward copy:** preload 0x0010..0x0013 = 1, 2, 3, 4. Copy src=0x0010, dst=0x0012, len=4.
  - Required: 0x0012..0x0015 = 1, 2, 3, 4; first READ address 0x0013; first WRITE address 0x0015.
- **Zero length:** start with len=0.
  - Required: `done` in cycle 1; `busy` and `mem_we` never high; memory untouched.
- **Ignored start and mid-transfer reset:** start copy len=4, pulse `start` again in cycle 2 with different operands, and confirm it is ignored. Deassert `rst_n` mid-cycle 3.
  - Required: `mem_we`/`busy` drop immediately and asynchronously; no `done`.
  - After reset release, a new fill len=1 completes with `done` in cycle 2.
- **Address wrap:** fill dst=0xFFFE, len=3, value 0x1234.
  - Required: writes to 0xFFFE, 0xFFFF, 0x0000 in cycles 1–3; 0x0001 unchanged.
